data_memory_pipelined: RTL and testbench
========================================

Name: data_memory_pipelined

Overview:
- Parametrised successor to the processor's single-port data memory.
- Adds a valid/ready request handshake, per-byte write enables, a configurable read latency with a fully pipelined response path, out-of-range error reporting, and a hardware clear sequence after reset.
- Sits between the datapath's load/store unit and the word-addressed storage array. The processor stalls on req_ready low and on a missing resp_valid.

Parameters:
- WORD, 16, data width in bits; must be a multiple of 8.
- LENGTH, 1024, number of words implemented; must be ≤ 2**ADDRESSL.
- ADDRESSL, 10, word-address width.
- LAT, 1, read/write response latency in cycles; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present this cycle
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDRESSL  word address
- req_wdata  in  WORD  store data
- req_be  in  WORD/8  byte enables; bit i covers bits [8i+7:8i]
- resp_valid  out  1  one-cycle pulse per accepted request
- resp_rdata  out  WORD  load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; 1 = address ≥ LENGTH (or parity fault when the optional feature is enabled)

Behaviour:
- States: CLEAR and RUN.
- rst high at an edge → state CLEAR, clear_idx=0, all pipeline valids cleared. Outputs during reset and CLEAR: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
- CLEAR: writes 0 to memory[clear_idx] each cycle and increments. After the write of LENGTH-1 → RUN. Clear takes exactly LENGTH cycles after rst deasserts.
- RUN: req_ready=1 every cycle; no backpressure on responses. One request per cycle; accepted when req_valid && req_ready.
- Store, in range: at the accepting edge, each byte with req_be[i]=1 is updated; other bytes are unchanged. Response has rdata=0, err=0.
- Load, in range: the array is read at the accepting edge. The result enters a LAT-stage shift register (the first stage is the registered read).
- Response timing: resp_valid asserts exactly LAT cycles after the accepting edge, in request order. Back-to-back requests yield back-to-back responses (throughput 1/cycle).
- Out-of-range (addr ≥ LENGTH): no array access; response has err=1, rdata=0.
- Read-after-write: a load accepted the cycle after a store to the same address returns the new data.
- req_be=0 on a store: no bytes change, but a normal response is still returned.
- Address wrap: none. Addresses ≥ LENGTH are always errors and never alias.
- Reset mid-operation: in-flight responses are discarded. Stores already accepted have committed, and CLEAR then zeroes them.
- req_valid is ignored while req_ready=0; the requester must hold or retry.

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - Stores one even-parity bit per byte, written with the byte.
  - A load recomputes parity over all bytes; any mismatch → resp_err=1 and rdata still returned.
  - Extra input port par_inject (1 bit): when high with an accepted store, the stored parity of every enabled byte is inverted.
  - CLEAR writes correct parity (0).
- Undefined: no parity storage, no par_inject port; resp_err reflects range only.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum {DMEM_CLEAR, DMEM_RUN};
  - localparam function be_width(WORD)=WORD/8;
  - constant DMEM_MAX_LAT=8;
  - the response struct {valid, err, rdata}.
- Natural sub-module: dmem_resp_pipe, a LAT-deep shift register of the response struct with synchronous clear, instantiated once.

Test Plan:
- Reset → count cycles until req_ready=1: exactly 1024 with defaults. Then load addr 0x3FF → rdata 0x0000, err=0.
- Store 0xBEEF to 0x010 with be=2'b11; next cycle load 0x010 → rdata 0xBEEF, resp_valid exactly LAT cycles after each accept.
- Store 0x1234 be=2'b01 over 0xBEEF at 0x010 → load returns 0xBE34. Store with be=2'b00 → load still 0xBE34.
- LENGTH=1000: load 0x3E8 → err=1, rdata=0. Store 0x3E8 is rejected with err=1, and addresses 0x000 and 0x3E7 are unchanged.
- LAT=4: 6 back-to-back loads of 0x000..0x005 (preloaded 0x0A..0x0F) → 6 consecutive resp_valid pulses starting at accept+4, with in-order data. Assert rst after 3 accepts → no further resp_valid and req_ready=0 for 1024 cycles.
- DMEM_PARITY_EN: store 0x00FF with par_inject=1, then load → err=1, rdata=0x00FF. Store again without inject → err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the pipelined data memory and its response pipe.
package dmem_pkg;

    typedef enum logic {DMEM_CLEAR, DMEM_RUN} dmem_state_e;

    localparam int DMEM_MAX_LAT  = 8;
    localparam int DMEM_DEF_WORD = 16;

    function automatic int be_width(input int word);
        return word / 8;
    endfunction

    // Default-width response; the top specialises rdata to its own WORD.
    typedef struct packed {
        logic                     valid;
        logic                     err;
        logic [DMEM_DEF_WORD-1:0] rdata;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_resp_pipe.sv
// LAT-deep shift register of response structs; clr empties every stage synchronously.
module dmem_resp_pipe
    import dmem_pkg::*;
#(
    parameter int  LAT    = 1,
    parameter type resp_t = dmem_resp_t
) (
    input  logic  clk,
    input  logic  clr,
    input  resp_t in_resp,
    output resp_t out_resp
);

    localparam int DEPTH = (LAT < 1) ? 1 : ((LAT > DMEM_MAX_LAT) ? DMEM_MAX_LAT : LAT);

    resp_t stage_q [DEPTH];
    resp_t stage_d [DEPTH];

    // NOTE: every element is assigned on every pass, so no latch can be inferred.
    always_comb begin
        stage_d[0] = in_resp;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all stages shift on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clr) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_resp = stage_q[DEPTH-1];

endmodule

// File: rtl/data_memory_pipelined.sv
// Word-addressed data memory with valid/ready requests, byte enables, LAT-cycle responses
// and a post-reset clear sweep. Optional per-byte parity under macro DMEM_PARITY_EN.
module data_memory_pipelined
    import dmem_pkg::*;
#(
    parameter int WORD     = 16,
    parameter int LENGTH   = 1024,
    parameter int ADDRESSL = 10,
    parameter int LAT      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDRESSL-1:0]       req_addr,
    input  logic [WORD-1:0]           req_wdata,
    input  logic [be_width(WORD)-1:0] req_be,
`ifdef DMEM_PARITY_EN
    input  logic                      par_inject,
`endif
    output logic                      resp_valid,
    output logic [WORD-1:0]           resp_rdata,
    output logic                      resp_err
);

    localparam int                  BE       = be_width(WORD);
    localparam logic [ADDRESSL:0]   LEN_EXT  = (ADDRESSL+1)'(LENGTH);
    localparam logic [ADDRESSL-1:0] LAST_IDX = ADDRESSL'(LENGTH - 1);

    typedef struct packed {
        logic            valid;
        logic            err;
        logic [WORD-1:0] rdata;
    } resp_t;

    dmem_state_e         state_q, state_d;
    logic [ADDRESSL-1:0] clear_idx_q, clear_idx_d;

    // NOTE: the array has no reset; the CLEAR sweep zeroes it after every reset instead.
    logic [WORD-1:0]     mem_q [LENGTH];

    logic                accept;
    logic                in_range;
    logic                mem_we;
    logic [ADDRESSL-1:0] mem_waddr;
    logic [WORD-1:0]     mem_wdata;
    logic [BE-1:0]       mem_wbe;
    logic [WORD-1:0]     rd_word;
    logic                par_bad;
    resp_t               pipe_in, pipe_out;

    assign in_range  = {1'b0, req_addr} < LEN_EXT;
    assign req_ready = (state_q == DMEM_RUN) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        if (state_q == DMEM_CLEAR) begin
            clear_idx_d = clear_idx_q + 1'b1;
            if (clear_idx_q == LAST_IDX) begin
                state_d = DMEM_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DMEM_CLEAR;
            clear_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    // Single write port shared by the clear sweep and accepted in-range stores.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = req_wdata;
        mem_wbe   = req_be;
        if (state_q == DMEM_CLEAR && !rst) begin
            mem_we    = 1'b1;
            mem_waddr = clear_idx_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else if (accept && req_write && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE; i++) begin
                if (mem_wbe[i]) begin
                    mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = in_range ? mem_q[req_addr] : '0;

`ifdef DMEM_PARITY_EN
    logic [BE-1:0] par_q [LENGTH];
    logic [BE-1:0] par_wdata;
    logic [BE-1:0] rd_par;

    // Even parity per byte; an injected store flips the stored bit of each enabled byte.
    always_comb begin
        for (int i = 0; i < BE; i++) begin
            par_wdata[i] = (^mem_wdata[8*i +: 8]) ^ (par_inject && accept);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE; i++) begin
                if (mem_wbe[i]) begin
                    par_q[mem_waddr][i] <= par_wdata[i];
                end
            end
        end
    end

    assign rd_par = in_range ? par_q[req_addr] : '0;

    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < BE; i++) begin
            if (in_range && (rd_par[i] != (^rd_word[8*i +: 8]))) begin
                par_bad = 1'b1;
            end
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = accept;
        if (accept) begin
            if (!in_range) begin
                pipe_in.err = 1'b1;
            end else if (!req_write) begin
                pipe_in.rdata = rd_word;
                pipe_in.err   = par_bad;
            end
        end
    end

    dmem_resp_pipe #(
        .LAT    (LAT),
        .resp_t (resp_t)
    ) u_resp_pipe (
        .clk      (clk),
        .clr      (rst),
        .in_resp  (pipe_in),
        .out_resp (pipe_out)
    );

    // Responses are squashed combinationally while reset is held.
    assign resp_valid = pipe_out.valid && !rst;
    assign resp_err   = pipe_out.err && !rst;
    assign resp_rdata = rst ? '0 : pipe_out.rdata;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Directed bench: three instances (defaults, LENGTH=1000, LAT=4) sharing one clock.
module tb_data_memory_pipelined;

    logic        clk;
    logic        rst_v      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [9:0]  req_addr   [3];
    logic [15:0] req_wdata  [3];
    logic [1:0]  req_be     [3];
    logic        par_inject [3];
    logic        resp_valid [3];
    logic [15:0] resp_rdata [3];
    logic        resp_err   [3];

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_memory_pipelined dut_a (
        .clk(clk), .rst(rst_v[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]),
`ifdef DMEM_PARITY_EN
        .par_inject(par_inject[0]),
`endif
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_memory_pipelined #(.LENGTH(1000)) dut_b (
        .clk(clk), .rst(rst_v[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]),
`ifdef DMEM_PARITY_EN
        .par_inject(par_inject[1]),
`endif
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    data_memory_pipelined #(.LAT(4)) dut_c (
        .clk(clk), .rst(rst_v[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_be(req_be[2]),
`ifdef DMEM_PARITY_EN
        .par_inject(par_inject[2]),
`endif
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request from a negedge; return the first response seen and its latency in cycles.
    task automatic txn(input int u, input logic w, input logic [9:0] a, input logic [15:0] d,
                       input logic [1:0] be, input logic inj,
                       output logic [15:0] rd, output logic er, output int lat);
        req_valid[u]  = 1'b1;
        req_write[u]  = w;
        req_addr[u]   = a;
        req_wdata[u]  = d;
        req_be[u]     = be;
        par_inject[u] = inj;
        @(posedge clk);
        #1;
        req_valid[u]  = 1'b0;
        par_inject[u] = 1'b0;
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (resp_valid[u] === 1'b1) begin
                lat = n;
                rd  = resp_rdata[u];
                er  = resp_err[u];
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cnt, rdy_a, rdy_b, rdy_c;
        logic quiet;
        for (int u = 0; u < 3; u++) rst_v[u] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0 || resp_rdata[0] !== 16'h0 || resp_err[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, required all zero",
                     req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]);
        end
        for (int u = 0; u < 3; u++) rst_v[u] = 1'b0;
        cnt = 0; rdy_a = -1; rdy_b = -1; rdy_c = -1; quiet = 1'b1;
        while (cnt < 2000 && (rdy_a < 0 || rdy_b < 0 || rdy_c < 0)) begin
            @(posedge clk);
            #1;
            cnt++;
            if (req_ready[0] === 1'b1 && rdy_a < 0) rdy_a = cnt;
            if (req_ready[1] === 1'b1 && rdy_b < 0) rdy_b = cnt;
            if (req_ready[2] === 1'b1 && rdy_c < 0) rdy_c = cnt;
            if (resp_valid[0] !== 1'b0 || resp_valid[1] !== 1'b0 || resp_valid[2] !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (rdy_a != 1024) begin failures++; $display("FAIL clear_cycles_a: got %0d, required 1024", rdy_a); end
        checks++;
        if (rdy_b != 1000) begin failures++; $display("FAIL clear_cycles_b: got %0d, required 1000", rdy_b); end
        checks++;
        if (rdy_c != 1024) begin failures++; $display("FAIL clear_cycles_c: got %0d, required 1024", rdy_c); end
        checks++;
        if (quiet !== 1'b1) begin failures++; $display("FAIL clear_quiet: resp_valid seen during CLEAR, required none"); end
        @(negedge clk);
    endtask

    task automatic test_clear_contents();
        logic [15:0] rd; logic er; int lat;
        txn(0, 1'b0, 10'h3FF, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h0000 || er !== 1'b0 || lat != 1) begin
            failures++; $display("FAIL clear_load_3ff: rdata=%h err=%b lat=%0d, required 0000/0/1", rd, er, lat);
        end
        txn(0, 1'b0, 10'h010, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h0000 || er !== 1'b0 || lat != 1) begin
            failures++; $display("FAIL clear_load_010: rdata=%h err=%b lat=%0d, required 0000/0/1", rd, er, lat);
        end
    endtask

    task automatic test_read_after_write();
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 10'h010;
        req_wdata[0] = 16'hBEEF; req_be[0] = 2'b11;
        @(posedge clk);
        #1;
        req_write[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 16'h0 || resp_err[0] !== 1'b0) begin
            failures++; $display("FAIL raw_store_resp: valid=%b rdata=%h err=%b, required 1/0000/0",
                                 resp_valid[0], resp_rdata[0], resp_err[0]);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 16'hBEEF || resp_err[0] !== 1'b0) begin
            failures++; $display("FAIL raw_load_resp: valid=%b rdata=%h err=%b, required 1/beef/0",
                                 resp_valid[0], resp_rdata[0], resp_err[0]);
        end
        @(negedge clk);
        checks++;
        if (resp_valid[0] !== 1'b0) begin
            failures++; $display("FAIL resp_pulse: valid=%b one cycle later, required 0", resp_valid[0]);
        end
    endtask

    task automatic test_byte_enable();
        logic [15:0] rd; logic er; int lat;
        txn(0, 1'b1, 10'h010, 16'h1234, 2'b01, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h0 || er !== 1'b0 || lat != 1) begin
            failures++; $display("FAIL be01_store_resp: rdata=%h err=%b lat=%0d, required 0000/0/1", rd, er, lat);
        end
        txn(0, 1'b0, 10'h010, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'hBE34 || er !== 1'b0) begin
            failures++; $display("FAIL be01_load: rdata=%h err=%b, required be34/0", rd, er);
        end
        txn(0, 1'b1, 10'h010, 16'hFFFF, 2'b00, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h0 || er !== 1'b0 || lat != 1) begin
            failures++; $display("FAIL be00_store_resp: rdata=%h err=%b lat=%0d, required 0000/0/1", rd, er, lat);
        end
        txn(0, 1'b0, 10'h010, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'hBE34 || er !== 1'b0) begin
            failures++; $display("FAIL be00_load: rdata=%h err=%b, required be34/0", rd, er);
        end
        txn(0, 1'b1, 10'h010, 16'hAB00, 2'b10, 1'b0, rd, er, lat);
        txn(0, 1'b0, 10'h010, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'hAB34 || er !== 1'b0) begin
            failures++; $display("FAIL be10_load: rdata=%h err=%b, required ab34/0", rd, er);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] rd; logic er; int lat;
        txn(1, 1'b1, 10'h000, 16'h1111, 2'b11, 1'b0, rd, er, lat);
        txn(1, 1'b1, 10'h3E7, 16'h2222, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h0 || er !== 1'b0 || lat != 1) begin
            failures++; $display("FAIL oor_last_store: rdata=%h err=%b lat=%0d, required 0000/0/1", rd, er, lat);
        end
        txn(1, 1'b0, 10'h3E8, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h0 || er !== 1'b1 || lat != 1) begin
            failures++; $display("FAIL oor_load_3e8: rdata=%h err=%b lat=%0d, required 0000/1/1", rd, er, lat);
        end
        txn(1, 1'b1, 10'h3E8, 16'h5555, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h0 || er !== 1'b1 || lat != 1) begin
            failures++; $display("FAIL oor_store_3e8: rdata=%h err=%b lat=%0d, required 0000/1/1", rd, er, lat);
        end
        txn(1, 1'b0, 10'h000, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h1111 || er !== 1'b0) begin
            failures++; $display("FAIL oor_keep_000: rdata=%h err=%b, required 1111/0", rd, er);
        end
        txn(1, 1'b0, 10'h3E7, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h2222 || er !== 1'b0) begin
            failures++; $display("FAIL oor_keep_3e7: rdata=%h err=%b, required 2222/0", rd, er);
        end
        txn(1, 1'b0, 10'h3FF, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h0 || er !== 1'b1) begin
            failures++; $display("FAIL oor_load_3ff: rdata=%h err=%b, required 0000/1", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd; logic er; int lat;
        logic exp_v; logic [15:0] exp_d;
        for (int i = 0; i < 6; i++) begin
            txn(2, 1'b1, 10'(i), 16'h000A + 16'(i), 2'b11, 1'b0, rd, er, lat);
            checks++;
            if (lat != 4 || er !== 1'b0) begin
                failures++; $display("FAIL lat4_store_%0d: lat=%0d err=%b, required 4/0", i, lat, er);
            end
        end
        for (int k = 0; k < 12; k++) begin
            req_valid[2] = (k < 6);
            req_write[2] = 1'b0;
            req_addr[2]  = 10'(k);
            @(posedge clk);
            @(negedge clk);
            exp_v = (k >= 3 && k <= 8);
            exp_d = exp_v ? 16'h000A + 16'(k - 3) : 16'h0;
            checks++;
            if (resp_valid[2] !== exp_v || resp_rdata[2] !== exp_d || resp_err[2] !== 1'b0) begin
                failures++; $display("FAIL b2b_cycle_%0d: valid=%b rdata=%h err=%b, required %b/%h/0",
                                     k, resp_valid[2], resp_rdata[2], resp_err[2], exp_v, exp_d);
            end
        end
        req_valid[2] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd; logic er; int lat;
        int cnt, rdy;
        logic quiet;
        for (int k = 0; k < 3; k++) begin
            req_valid[2] = 1'b1;
            req_write[2] = 1'b0;
            req_addr[2]  = 10'(k);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid[2] = 1'b0;
        rst_v[2] = 1'b1;
        #1;
        checks++;
        if (req_ready[2] !== 1'b0 || resp_valid[2] !== 1'b0) begin
            failures++; $display("FAIL mid_reset_gate: ready=%b valid=%b, required 0/0", req_ready[2], resp_valid[2]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_v[2] = 1'b0;
        cnt = 0; rdy = -1; quiet = 1'b1;
        while (cnt < 1100 && rdy < 0) begin
            @(posedge clk);
            #1;
            cnt++;
            if (resp_valid[2] !== 1'b0) quiet = 1'b0;
            if (req_ready[2] === 1'b1) rdy = cnt;
        end
        checks++;
        if (rdy != 1024) begin failures++; $display("FAIL mid_reset_clear: ready after %0d cycles, required 1024", rdy); end
        checks++;
        if (quiet !== 1'b1) begin failures++; $display("FAIL mid_reset_discard: resp_valid seen after reset, required none"); end
        @(negedge clk);
        txn(2, 1'b0, 10'h002, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h0 || er !== 1'b0 || lat != 4) begin
            failures++; $display("FAIL mid_reset_zeroed: rdata=%h err=%b lat=%0d, required 0000/0/4", rd, er, lat);
        end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        logic [15:0] rd; logic er; int lat;
        txn(0, 1'b1, 10'h030, 16'h00FF, 2'b11, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 16'h0 || er !== 1'b0) begin
            failures++; $display("FAIL par_inject_store: rdata=%h err=%b, required 0000/0", rd, er);
        end
        txn(0, 1'b0, 10'h030, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h00FF || er !== 1'b1) begin
            failures++; $display("FAIL par_inject_load: rdata=%h err=%b, required 00ff/1", rd, er);
        end
        txn(0, 1'b1, 10'h030, 16'h00FF, 2'b11, 1'b0, rd, er, lat);
        txn(0, 1'b0, 10'h030, 16'h0, 2'b11, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 16'h00FF || er !== 1'b0) begin
            failures++; $display("FAIL par_clean_load: rdata=%h err=%b, required 00ff/0", rd, er);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        for (int u = 0; u < 3; u++) begin
            rst_v[u]      = 1'b1;
            req_valid[u]  = 1'b0;
            req_write[u]  = 1'b0;
            req_addr[u]   = '0;
            req_wdata[u]  = '0;
            req_be[u]     = '0;
            par_inject[u] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_clear_contents();
        test_read_after_write();
        test_byte_enable();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
